// File: rtl/toggle_sig_pkg.sv
// Shared definitions for the two-phase toggle signalling blocks.
//   tgl_dec_state_t : receive-side state machine encoding (ALIGN, RUN)
//   TGL_SYNC_MIN    : smallest usable synchroniser depth
package toggle_sig_pkg;

   typedef enum logic {
      ALIGN = 1'b0,
      RUN   = 1'b1
   } tgl_dec_state_t;

   localparam int unsigned TGL_SYNC_MIN = 2;

endpackage

// File: rtl/level_sync.sv
// Multi-flop level synchroniser with asynchronous active-high reset.
// Shared by the sender and receiver sides of the toggle link.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears every stage
//   d_i   : level to synchronise (may be asynchronous to clk_i)
//   q_o   : synchronised level, last stage of the chain
module level_sync
   import toggle_sig_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   // Depths below the minimum are raised rather than silently producing
   // a metastability-prone single-flop path.
   localparam int unsigned N = (STAGES < TGL_SYNC_MIN) ? TGL_SYNC_MIN : STAGES;

   logic [N-1:0] s_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_q <= '0;
      end else begin
         s_q <= {s_q[N-2:0], d_i};
      end
   end

   assign q_o = s_q[N-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Receive side of the two-phase toggle link. Synchronises tgl_in, turns each
// level flip into one event, queues up to DEPTH events behind a valid/ready
// handshake and flips ack_tgl once per consumed event.
//   clk       : sole clock, rising edge
//   reset     : asynchronous active-high reset
//   tgl_in    : toggle level from the sender
//   evt_ready : consumer takes one event per cycle while evt_valid is high
//   ovf_clr   : clears the sticky overflow flag
//   evt_valid : at least one event pending
//   pending   : number of queued events, 0..DEPTH
//   ack_tgl   : flips once per accepted event
//   overflow  : sticky, an event was dropped because the queue was full
//   running   : block is in the RUN state
module toggle_event_decoder
   import toggle_sig_pkg::*;
#(
   parameter  int unsigned SYNC_STAGES = 2,
   parameter  int unsigned DEPTH       = 7,
   localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tgl_in,
   input  logic             evt_ready,
   input  logic             ovf_clr,
   output logic             evt_valid,
   output logic [CNT_W-1:0] pending,
   output logic             ack_tgl,
   output logic             overflow,
   output logic             running
);

   localparam int unsigned SYNC_N = (SYNC_STAGES < TGL_SYNC_MIN) ? TGL_SYNC_MIN : SYNC_STAGES;
   localparam int unsigned ALN_W  = $clog2(SYNC_N + 1);

   tgl_dec_state_t   state_q, state_d;
   logic [ALN_W-1:0] aln_cnt_q, aln_cnt_d;
   logic             prev_q, prev_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             ack_q, ack_d;
   logic             ovf_q, ovf_d;

   logic             sync_lvl;
   logic             edge_det;
   logic             accept;
   logic             full;

   level_sync #(
      .STAGES (SYNC_N)
   ) u_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (tgl_in),
      .q_o   (sync_lvl)
   );

   assign full     = (pending_q == CNT_W'(DEPTH));
   assign accept   = evt_valid & evt_ready;
   // Edges are ignored while aligning so the level present at reset
   // release is absorbed into prev_q instead of being reported.
   assign edge_det = (state_q == RUN) & (sync_lvl ^ prev_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ALIGN;
         aln_cnt_q <= ALN_W'(SYNC_N);
         prev_q    <= 1'b0;
         pending_q <= '0;
         ack_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         aln_cnt_q <= aln_cnt_d;
         prev_q    <= prev_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      aln_cnt_d = aln_cnt_q;
      prev_d    = sync_lvl;
      pending_d = pending_q;
      ack_d     = ack_q ^ accept;
      ovf_d     = ovf_q;

      case (state_q)
         ALIGN: begin
            if (aln_cnt_q == '0) begin
               state_d = RUN;
            end else begin
               aln_cnt_d = aln_cnt_q - ALN_W'(1);
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = ALIGN;
         end
      endcase

      if (ovf_clr) begin
         ovf_d = 1'b0;
      end

      // Edge and accept together cancel out, so a full queue is not an
      // overflow in that cycle. A drop in the same cycle as ovf_clr wins.
      if (edge_det && !accept) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            pending_d = pending_q + CNT_W'(1);
         end
      end else if (accept && !edge_det) begin
         pending_d = pending_q - CNT_W'(1);
      end
   end

   assign evt_valid = (pending_q != '0);
   assign pending   = pending_q;
   assign ack_tgl   = ack_q;
   assign overflow  = ovf_q;
   assign running   = (state_q == RUN);

endmodule

// File: doc/toggle_event_decoder.md
# toggle_event_decoder

Receive side of the two-phase toggle signalling scheme. The sender flips one level, `tgl_in`, once per event. This block synchronises that level and recovers each flip as a discrete event. It queues up to `DEPTH` events behind a valid/ready handshake and flips `ack_tgl` once per consumed event, so the sender can track completion. It sits at the boundary where toggle-encoded events from a T-flop-style source enter the `clk` domain.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth; must be ≥2.
- `DEPTH`, 7: maximum pending events; must be ≥1.
- `CNT_W`, derived localparam equal to `$clog2(DEPTH+1)`: width of the pending-event count.

Ports:
- `clk`, input, 1: the only clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `tgl_in`, input, 1: toggle level from the sender; may be asynchronous to `clk`.
- `evt_ready`, input, 1: consumer accepts one event per cycle while `evt_valid` is high.
- `ovf_clr`, input, 1: clears `overflow`.
- `evt_valid`, output, 1: at least one event is pending.
- `pending`, output, `CNT_W`: number of queued events, 0..`DEPTH`.
- `ack_tgl`, output, 1: flips once per accepted event.
- `overflow`, output, 1: sticky; an event was dropped.
- `running`, output, 1: block is in the RUN state.

## Operation
State machine:
- **ALIGN**: entered on reset. A down-counter is loaded with `SYNC_STAGES`.
  - Each cycle, the previous-level register `prev` loads the last synchroniser stage `s[SYNC_STAGES-1]`.
  - No events are detected, so a level change on `tgl_in` during ALIGN produces no event.
  - When the counter reaches 0, the block moves to RUN.
- **RUN**: stays in RUN until `reset`.
  - `edge` is `s[SYNC_STAGES-1] ^ prev`.
  - `prev` loads `s[SYNC_STAGES-1]` every cycle.

Handshake:
- `accept` is `evt_valid & evt_ready`.
- `evt_valid` is `pending != 0`, driven from registers, never combinationally from `evt_ready`.

`pending` update, at most ±1 per cycle:
- `edge` without `accept`: increment. If `pending == DEPTH`, hold the count, drop the event and set `overflow`.
- `accept` without `edge`: decrement.
- `edge` and `accept` together: hold. This is not an overflow, even at `DEPTH`.

Other outputs:
- `ack_tgl` flips on every `accept`.
- `overflow` clears when `ovf_clr` is high.
  - If `ovf_clr` and a new drop occur in the same cycle, the set wins and `overflow` stays 1.
- `evt_ready` while `pending == 0` has no effect.

Reset values:
- All synchroniser stages, `prev`, `pending`, `ack_tgl`, `overflow` and `running` are 0.
- `evt_valid` is 0.
- State is ALIGN.

## Timing
- ALIGN lasts `SYNC_STAGES+1` cycles after `reset` deasserts. `running` rises on the following edge.
- Event latency: `tgl_in` changes before edge 0; `evt_valid` and `pending` update after edge `SYNC_STAGES`. With the default, this is 3 edges including edge 0.
- Toggles spaced less than 2 `clk` periods apart may merge. The sender guarantees a spacing of ≥2 periods.
- `ack_tgl` updates on the same edge that consumes the event.
- Throughput: one event per cycle in and one per cycle out.
- Reset asserted mid-operation discards pending events immediately, with no drain.

## Structure
- A shared package `toggle_sig_pkg` holds:
  - the state enum `tgl_dec_state_t` with values ALIGN and RUN;
  - the constant `TGL_SYNC_MIN = 2`.
- One sub-module, `level_sync`, is the parameterised `SYNC_STAGES` flop chain with asynchronous reset. It is shared with the sender side.
- The FSM, counter and handshake logic live in the top level.

## Test plan
- **Reset and align:** `tgl_in` = 1 held through reset and release.
  - Required: `running` rises after ALIGN; `pending` stays 0 and no event is reported.
- **Single event:** in RUN, `tgl_in` 0→1 with `evt_ready` = 0.
  - Required: `pending` = 1 and `evt_valid` = 1 exactly 3 edges later.
  - Then pulse `evt_ready` for 1 cycle: `pending` = 0 and `ack_tgl` flips 0→1.
- **Fill and overflow:** 8 toggles spaced 2 cycles apart with `evt_ready` = 0 and `DEPTH` = 7.
  - Required: `pending` = 7 and `overflow` = 1.
  - `ovf_clr` pulse then clears `overflow`; `pending` stays 7.
- **Simultaneous edge and accept at full:** `pending` = 7, `evt_ready` = 1 in the same cycle a toggle is detected.
  - Required: `pending` remains 7, `overflow` remains 0, `ack_tgl` flips once.
- **Streaming:** 20 toggles spaced 2 cycles apart with `evt_ready` held at 1.
  - Required: exactly 20 `ack_tgl` flips; final `ack_tgl` = 0; `pending` never exceeds 1.
- **Reset mid-operation:** assert `reset` with `pending` = 4.
  - Required: `pending`, `evt_valid`, `ack_tgl` and `overflow` go to 0 immediately, without waiting for a `clk` edge.
